// File: rtl/onehot_enc_pkg.sv
`default_nettype none
// ============================================================================
// onehot_enc_pkg : shared constants and FSM state type for the scan encoder
// Revision 1.0
// ============================================================================
package onehot_enc_pkg;

    localparam int WIDTH_DEF = 16;
    localparam int IDXW_DEF  = 4;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } scan_state_t;

endpackage
`default_nettype wire

// File: rtl/onehot_scan_encoder_lsb_prio_enc.sv
`default_nettype none
// ============================================================================
// lsb_prio_enc : combinational lowest-set-bit priority encoder
// Revision 1.0
// ============================================================================
module lsb_prio_enc
    import onehot_enc_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int IDXW  = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] vec,
    output logic [IDXW-1:0]  idx,
    output logic             any,
    output logic             single
);

    // Descending scan so the lowest set bit is the last one to win.
    always_comb begin
        idx = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = IDXW'(i);
            end
        end
    end

    assign any    = |vec;
    assign single = ((vec & (vec - WIDTH'(1))) == '0);

endmodule
`default_nettype wire

// File: rtl/onehot_scan_encoder.sv
`default_nettype none
// ============================================================================
// onehot_scan_encoder : emits the index of every set bit of an accepted
// vector, one beat per index, lowest first (inverse of a one-hot decoder)
// Revision 1.0
// ============================================================================
module onehot_scan_encoder
    import onehot_enc_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int IDXW  = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_vec,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDXW-1:0]  out_idx,
    output logic             out_last,
    output logic             out_none
);

    scan_state_t      r_state;
    scan_state_t      w_state_next;
    logic [WIDTH-1:0] r_pending;
    logic             r_none;

    logic [IDXW-1:0]  w_idx;
    logic             w_any;
    logic             w_single;
    logic             w_accept;
    logic             w_beat;

    lsb_prio_enc #(
        .WIDTH (WIDTH),
        .IDXW  (IDXW)
    ) u_lsb_prio_enc (
        .vec    (r_pending),
        .idx    (w_idx),
        .any    (w_any),
        .single (w_single)
    );

    assign w_accept = (r_state == IDLE) && in_valid;
    assign w_beat   = (r_state == SCAN) && out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (in_valid)             w_state_next = SCAN;
            SCAN:    if (out_ready && w_single) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pending <= '0;
            r_none    <= 1'b0;
        end else if (w_accept) begin
            r_pending <= in_vec;
            r_none    <= (in_vec == '0);
        end else if (w_beat) begin
            if (w_single) begin
                r_pending <= '0;
                r_none    <= 1'b0;
            end else begin
                r_pending <= r_pending & ~(WIDTH'(1) << w_idx);
            end
        end
    end

    // Outputs gated by state so the idle values match reset regardless of pending.
    always_comb begin
        in_ready  = (r_state == IDLE);
        out_valid = (r_state == SCAN);
        out_idx   = '0;
        out_last  = 1'b0;
        out_none  = 1'b0;
        if (r_state == SCAN) begin
            out_idx  = w_any ? w_idx : '0;
            out_last = w_single;
            out_none = r_none;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_onehot_scan_encoder.sv
`default_nettype none
// ============================================================================
// tb_onehot_scan_encoder : randomized and directed bench with reference model
// Revision 1.0
// ============================================================================
module tb_onehot_scan_encoder;

    localparam int WIDTH = 16;
    localparam int IDXW  = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_vec;
    logic             out_valid;
    logic             out_ready;
    logic [IDXW-1:0]  out_idx;
    logic             out_last;
    logic             out_none;

    int checks = 0;
    int errors = 0;

    onehot_scan_encoder #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_vec    (in_vec),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .out_none  (out_none)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // mode 0: ready always high, 1: ready pattern 1,0,0 repeating, 2: random ready
    task automatic run_vector(input logic [WIDTH-1:0] vec, input int mode, input bit noisy);
        int exp_q[$];
        bit none_exp;
        int cyc;
        int waited;
        bit rdy;

        for (int i = 0; i < WIDTH; i++)
            if (vec[i]) exp_q.push_back(i);
        none_exp = (exp_q.size() == 0);
        if (none_exp) exp_q.push_back(0);

        waited = 0;
        while (in_ready !== 1'b1 && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        check("wait_in_ready", in_ready, 1'b1);
        in_valid = 1'b1;
        in_vec   = vec;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        in_vec   = WIDTH'($urandom);

        cyc = 0;
        while (exp_q.size() > 0) begin
            if (cyc > 200) begin
                check("beat_budget", cyc, 0);
                break;
            end
            check("out_valid", out_valid, 1'b1);
            check("in_ready_busy", in_ready, 1'b0);
            check("out_idx", out_idx, exp_q[0]);
            check("out_last", out_last, exp_q.size() == 1);
            check("out_none", out_none, none_exp);
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = (cyc % 3 == 0);
                default: rdy = 1'($urandom);
            endcase
            out_ready = rdy;
            if (noisy) begin
                in_valid = 1'($urandom);
                in_vec   = WIDTH'($urandom);
            end
            @(posedge clk);
            @(negedge clk);
            if (rdy) void'(exp_q.pop_front());
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("turnaround_in_ready", in_ready, 1'b1);
        check("turnaround_out_valid", out_valid, 1'b0);
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b1;
        in_vec    = 16'hFFFF;
        out_ready = 1'b1;

        // Reset held with inputs active
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("reset_out_valid", out_valid, 1'b0);
        end
        reset    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("post_reset_in_ready", in_ready, 1'b1);
        check("post_reset_out_valid", out_valid, 1'b0);
        check("post_reset_out_idx", out_idx, 0);
        check("post_reset_out_last", out_last, 1'b0);
        check("post_reset_out_none", out_none, 1'b0);

        for (int k = 0; k < WIDTH; k++) run_vector(WIDTH'(1) << k, 0, 1'b0);
        run_vector(16'h8421, 0, 1'b0);
        run_vector(16'hFFFF, 1, 1'b0);
        run_vector(16'h0000, 0, 1'b0);
        run_vector(16'h0000, 2, 1'b1);
        run_vector(16'h8000, 1, 1'b1);

        for (int n = 0; n < 60; n++) begin
            logic [WIDTH-1:0] v;
            v = WIDTH'($urandom);
            if (n % 3 == 1) v = v & WIDTH'($urandom) & WIDTH'($urandom);
            run_vector(v, n % 3, n[0]);
        end

        // Reset in the middle of a scan: beats 4 and 5 transfer, then reset
        in_valid = 1'b1;
        in_vec   = 16'h00F0;
        @(posedge clk);
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("mid_beat4", out_idx, 4);
        @(posedge clk);
        @(negedge clk);
        check("mid_beat5", out_idx, 5);
        @(posedge clk);
        @(negedge clk);
        check("mid_pending6", out_idx, 6);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("mid_reset_out_valid", out_valid, 1'b0);
        check("mid_reset_out_idx", out_idx, 0);
        reset = 1'b0;
        @(negedge clk);
        check("mid_release_in_ready", in_ready, 1'b1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("mid_no_stale_beat", out_valid, 1'b0);
        end
        out_ready = 1'b0;
        run_vector(16'h0081, 0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/onehot_scan_encoder.md
# onehot_scan_encoder

Sequential encoder that performs the inverse of the 4-to-16 one-hot decoder. It accepts a 16-bit vector over a valid/ready handshake and emits the 4-bit index of every set bit, one index per beat, lowest index first. It sits between request/flag producers and any logic that consumes binary indices. Each decoder output can be round-tripped through this block to recover the original 4-bit code.

## Interface
Parameters:
- WIDTH, 16: input vector width. Must be a power of two, at least 2.
- IDXW, $clog2(WIDTH) = 4: index width. Derived; do not override.

Ports:
- clk  input  1  clock; all logic is on the rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  in_vec is presented.
- in_ready  output  1  block can accept a vector.
- in_vec  input  WIDTH  vector to encode.
- out_valid  output  1  out_idx, out_last and out_none are valid.
- out_ready  input  1  consumer accepts the current beat.
- out_idx  output  IDXW  index of the lowest pending set bit.
- out_last  output  1  current beat is the final beat of this vector.
- out_none  output  1  accepted vector was all-zero; only beat, with out_idx = 0.

## Operation
- FSM states: IDLE and SCAN.
- IDLE:
  - in_ready = 1 and out_valid = 0.
  - When in_valid && in_ready: load pending <= in_vec, set none_q <= (in_vec == 0), then go to SCAN.
- SCAN:
  - in_ready = 0 and out_valid = 1.
  - out_idx = index of the lowest set bit of pending, or 0 if pending == 0.
  - out_last = 1 when pending has at most one bit set, i.e. (pending & (pending - 1)) == 0.
  - out_none = none_q.
- Beat handshake: a beat transfers when out_valid && out_ready.
  - Not last: clear bit out_idx in pending and stay in SCAN.
  - Last: go to IDLE and clear pending and none_q.
- Backpressure: while out_valid && !out_ready, out_idx, out_last and out_none must hold stable.
- Zero vector: produces exactly one beat with out_none = 1, out_idx = 0, out_last = 1.
- Beats per vector = popcount(in_vec), or 1 for a zero vector.
- in_vec is sampled only on the accept cycle. Later changes to in_vec are ignored.
- in_valid while in_ready = 0 is ignored. The producer must hold the vector until it is accepted.
- out_* are driven from registered state (pending, none_q, state) through combinational decode only. There is no path from in_* to out_*.

## Timing
- Reset values:
  - state = IDLE, pending = 0, none_q = 0.
  - out_valid = 0, out_idx = 0, out_last = 0, out_none = 0.
  - in_ready = 1 in the first cycle after reset deasserts. All inputs are ignored while reset is high.
- Latency: vector accepted at edge N → first beat has out_valid = 1 in cycle N+1.
- Throughput: with out_ready held high, one beat per cycle.
- Turnaround: last beat transfers at edge M → in_ready = 1 in cycle M+1, so the next vector is accepted at edge M+1 at the earliest. One bubble per vector.
- Reset mid-scan: takes priority over any handshake in the same cycle. Outputs return to reset values in the next cycle, and remaining bits are discarded.
- No wrap-around: the scan is strictly ascending from bit 0 to bit WIDTH-1.

## Structure
- Package onehot_enc_pkg contains:
  - localparam WIDTH_DEF = 16 and IDXW_DEF = 4.
  - typedef enum logic {IDLE, SCAN} scan_state_t.
- Sub-module lsb_prio_enc:
  - Purely combinational, parameter WIDTH.
  - Inputs: vec.
  - Outputs: idx (lowest set bit, 0 if none), any (vec != 0), single (at most one bit set).
  - The top level instantiates it once on pending.
- Top level contains the FSM, the pending and none_q registers, and the handshake.

## Test plan
- Reset: assert reset for 2 cycles with in_valid = 1 and in_vec = 16'hFFFF → out_valid = 0 throughout; in_ready = 1 in the first cycle after release.
- Decoder round-trip: for k = 0..15, send in_vec = 1 << k with out_ready = 1 → exactly one beat with out_idx = k, out_last = 1, out_none = 0, in the cycle after accept.
- Multi-bit scan: in_vec = 16'h8421, out_ready = 1 → beats on 4 consecutive cycles with out_idx 0, 5, 10, 15; out_last only on 15; in_ready = 1 the cycle after the last beat.
- Backpressure: in_vec = 16'hFFFF with out_ready toggling 1,0,0,1,… → 16 beats with out_idx 0..15 in order; outputs held stable across every stalled cycle; no beat lost or duplicated.
- Zero vector: in_vec = 16'h0000 → one beat with out_none = 1, out_idx = 0, out_last = 1, then back to IDLE.
- Reset mid-operation: in_vec = 16'h00F0, reset asserted after beats 4 and 5 → out_valid = 0 next cycle, in_ready = 1 after release, and indices 6 and 7 are never emitted.
